// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch control bundle.
// Groups the switch/button inputs, the BCD digits fed back from the
// datapath, and the control outputs of stopwatch_ctrl.
//   master : drives switches, buttons and digits; observes control outputs
//   slave  : the controller (stopwatch_ctrl)
interface stopwatch_ctrl_if;
    logic       start;       // run switch, level
    logic       up;          // direction switch, 1 = count up
    logic       plus_min2;   // add-2-minutes button
    logic       sw_clear;    // clear button
    logic       speedup;     // fast-rate request, level
    logic       slowdown;    // slow-rate request, level
    logic [3:0] ss0;         // seconds, units
    logic [3:0] ss1;         // seconds, tens
    logic [3:0] mm0;         // minutes, units
    logic [3:0] mm1;         // minutes, tens
    logic       cnt_en;      // one-cycle count pulse
    logic       cnt_up;      // latched direction
    logic       add2_pulse;  // one-cycle add-2-minutes command
    logic       clr_pulse;   // one-cycle clear command
    logic [1:0] state;       // FSM state
    logic       running;     // state is RUN
    logic       at_limit;    // end of count for the current direction

    modport master (
        output start, up, plus_min2, sw_clear, speedup, slowdown,
        output ss0, ss1, mm0, mm1,
        input  cnt_en, cnt_up, add2_pulse, clr_pulse, state, running, at_limit
    );

    modport slave (
        input  start, up, plus_min2, sw_clear, speedup, slowdown,
        input  ss0, ss1, mm0, mm1,
        output cnt_en, cnt_up, add2_pulse, clr_pulse, state, running, at_limit
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller.
// Synchronizes the asynchronous switches/buttons, runs the IDLE/RUN/PAUSE/DONE
// FSM, and divides in_clk down to a count-tick pulse whose period is
// selectable (normal, fast, slow). The BCD digits live in an external
// datapath; this block only issues count/add/clear commands to it.
//   in_clk : sole clock, rising edge
//   reset  : asynchronous, active-low
//   sw     : stopwatch_ctrl_if.slave (inputs, digits, control outputs)
module stopwatch_ctrl #(
    parameter int TICK_DIV   = 50000000,  // in_clk cycles per tick, >= 64
    parameter int FAST_SHIFT = 4          // fast period = TICK_DIV >> FAST_SHIFT
) (
    input  logic           in_clk,
    input  logic           reset,
    stopwatch_ctrl_if.slave sw
);

    // Wide enough for the slow period without overflow.
    localparam int DIV_W = $clog2((TICK_DIV << 1) + 1);

    localparam logic [DIV_W-1:0] P_NORM = DIV_W'(TICK_DIV);
    localparam logic [DIV_W-1:0] P_FAST = DIV_W'(TICK_DIV >> FAST_SHIFT);
    localparam logic [DIV_W-1:0] P_SLOW = DIV_W'(TICK_DIV << 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Bit order: {slowdown, speedup, sw_clear, plus_min2, up, start}
    logic [5:0] sync1, sync2;
    logic [1:0] edge_prev;  // previous synchronized {sw_clear, plus_min2}

    state_t           state_q, state_next;
    logic [DIV_W-1:0] div_q, div_next;
    logic             cnt_up_q;

    logic start_s, up_s, speedup_s, slowdown_s;
    logic clr_rise, plus_rise;
    logic at_limit_c, add2_block;
    logic cnt_en_c, add2_c, clr_c;
    logic [DIV_W-1:0] period;

    assign start_s     = sync2[0];
    assign up_s        = sync2[1];
    assign speedup_s   = sync2[4];
    assign slowdown_s  = sync2[5];
    assign plus_rise   = sync2[2] & ~edge_prev[0];
    assign clr_rise    = sync2[3] & ~edge_prev[1];

    // Conflicting rate requests fall back to the normal period.
    always_comb begin
        period = P_NORM;
        if (speedup_s && !slowdown_s)
            period = P_FAST;
        else if (slowdown_s && !speedup_s)
            period = P_SLOW;
    end

    assign at_limit_c = cnt_up_q
        ? (sw.mm1 == 4'd9 && sw.mm0 == 4'd9 && sw.ss1 == 4'd5 && sw.ss0 == 4'd9)
        : (sw.mm1 == 4'd0 && sw.mm0 == 4'd0 && sw.ss1 == 4'd0 && sw.ss0 == 4'd0);

    // Adding two minutes at 98:xx or 99:xx would pass 99:59.
    assign add2_block = (sw.mm1 == 4'd9) && (sw.mm0 >= 4'd8);

    always_ff @(posedge in_clk or negedge reset) begin
        if (!reset) begin
            sync1     <= '0;
            sync2     <= '0;
            edge_prev <= '0;
        end else begin
            sync1     <= {sw.slowdown, sw.speedup, sw.sw_clear,
                          sw.plus_min2, sw.up, sw.start};
            sync2     <= sync1;
            edge_prev <= sync2[3:2];
        end
    end

    always_ff @(posedge in_clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            div_q    <= '0;
            cnt_up_q <= 1'b0;
        end else begin
            state_q <= state_next;
            div_q   <= div_next;
            // Direction is frozen while running so a count never reverses mid-run.
            if (state_q != RUN)
                cnt_up_q <= up_s;
        end
    end

    // Priority: clear rise, then plus rise, then the start level.
    // The three pulses come from exclusive branches, so they never coincide.
    always_comb begin
        state_next = state_q;
        div_next   = div_q;
        cnt_en_c   = 1'b0;
        add2_c     = 1'b0;
        clr_c      = 1'b0;
        if (clr_rise) begin
            clr_c      = 1'b1;
            state_next = IDLE;
            div_next   = '0;
        end else if (plus_rise && state_q != RUN && !add2_block) begin
            add2_c     = 1'b1;
            state_next = PAUSE;
        end else begin
            case (state_q)
                IDLE, PAUSE: begin
                    if (start_s && !at_limit_c)
                        state_next = RUN;
                end
                RUN: begin
                    if (at_limit_c) begin
                        state_next = DONE;
                    end else begin
                        // '>=' also catches a rate change that leaves the
                        // count above the new terminal value.
                        if (div_q >= period - 1'b1) begin
                            cnt_en_c = 1'b1;
                            div_next = '0;
                        end else begin
                            div_next = div_q + 1'b1;
                        end
                        if (!start_s)
                            state_next = PAUSE;
                    end
                end
                DONE: begin
                    if (!start_s)
                        state_next = PAUSE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign sw.cnt_en     = cnt_en_c;
    assign sw.add2_pulse = add2_c;
    assign sw.clr_pulse  = clr_c;
    assign sw.cnt_up     = cnt_up_q;
    assign sw.state      = state_q;
    assign sw.running    = (state_q == RUN);
    assign sw.at_limit   = at_limit_c;

endmodule
